serial_byte_queue: RTL and testbench

Serial-to-parallel receiver feeding an 8-entry FIFO, used as the top-level data path of the serial input subsystem. Single bits arrive on `data_in` and are qualified by rising edges of `write_in`. Every 8 bits are assembled MSB-first into a byte and pushed into the FIFO. Bytes are popped onto `data_out` on rising edges of `dequeue_in`; `status_out` tells the sender whether bits are currently accepted.

---
 rtl/serial_byte_queue.sv | 186 ++++++++++++++++++
 tb/tb_serial_byte_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_queue.sv
// serial_byte_queue: serial-to-parallel receiver feeding a small circular FIFO.
// Bits arrive MSB-first on data_in, qualified by rising edges of write_in.
// Completed words are pushed into the FIFO and popped onto data_out by
// rising edges of dequeue_in. status_out reports whether bits are accepted.
module serial_byte_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock_1MHz,
  input  logic             rst,
  input  logic             data_in,
  input  logic             write_in,
  input  logic             enqueue_in,
  input  logic             dequeue_in,
  output logic             status_out,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Receiver states: collecting bits, or holding a finished word for the FIFO
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  // Reserved input; intentionally has no effect
  logic unused_enqueue;
  assign unused_enqueue = enqueue_in;

  // Strobe synchronisation / edge detection registers
  logic write_q;
  logic write_prev;
  logic data_q;
  logic deq_q;
  logic deq_prev;

  // Receiver state
  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] shift;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] hold;
  logic             pending_blocked;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Combinational helpers
  logic             write_evt_c;
  logic             pop_evt_c;
  logic             pending_c;
  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             do_pop_c;
  logic             accept_c;
  logic             byte_done_c;
  logic [WIDTH-1:0] captured_word_c;

  assign write_evt_c     = write_q & ~write_prev;
  assign pop_evt_c       = deq_q & ~deq_prev;
  assign pending_c       = (state == ST_HOLD);
  assign full_c          = (count == CNT_W'(DEPTH));
  assign empty_c         = (count == '0);
  assign push_c          = pending_c & ~full_c;
  assign do_pop_c        = pop_evt_c & ~empty_c;
  assign accept_c        = write_evt_c & status_out & ~(pending_c & full_c);
  assign byte_done_c     = accept_c & (bit_cnt == BIT_W'(WIDTH - 1));
  assign captured_word_c = {shift[WIDTH-2:0], data_q};

  // Register strobes and the data bit seen alongside the write strobe
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      write_q    <= 1'b0;
      write_prev <= 1'b0;
      data_q     <= 1'b0;
      deq_q      <= 1'b0;
      deq_prev   <= 1'b0;
    end else begin
      write_q    <= write_in;
      write_prev <= write_q;
      data_q     <= data_in;
      deq_q      <= dequeue_in;
      deq_prev   <= deq_q;
    end
  end

  // Receiver state register
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Receiver next-state: a finished word is held until the FIFO takes it
  always_comb begin
    state_next = state;
    case (state)
      ST_COLLECT: begin
        if (byte_done_c) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (push_c && !byte_done_c) begin
          state_next = ST_COLLECT;
        end
      end
      default: begin
        state_next = ST_COLLECT;
      end
    endcase
  end

  // Shift register, bit counter and holding register
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
      hold    <= '0;
    end else if (accept_c) begin
      shift <= captured_word_c;
      if (byte_done_c) begin
        bit_cnt <= '0;
        hold    <= captured_word_c;
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // Stall flag and ready indication, lagging the FIFO state by one cycle
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      pending_blocked <= 1'b0;
      status_out      <= 1'b0;
    end else begin
      pending_blocked <= pending_c & full_c;
      status_out      <= ~pending_blocked;
    end
  end

  // FIFO storage write; contents are invalidated by count, not cleared
  always_ff @(posedge clock_1MHz) begin
    if (push_c) begin
      mem[wr_ptr] <= hold;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, do_pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Output word, held until the next successful pop
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      data_out <= '0;
    end else if (do_pop_c) begin
      data_out <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_serial_byte_queue.sv
// Directed testbench for serial_byte_queue with a scoreboard of expected words.
`timescale 1ns/1ps
module tb_serial_byte_queue;

  logic       clock_1MHz;
  logic       rst;
  logic       data_in;
  logic       write_in;
  logic       enqueue_in;
  logic       dequeue_in;
  logic       status_out;
  logic [7:0] data_out;

  int         n_checks;
  int         n_fails;
  logic [7:0] sb [$];
  logic [7:0] last_out;

  serial_byte_queue #(.DEPTH(8), .WIDTH(8)) dut (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .data_in    (data_in),
    .write_in   (write_in),
    .enqueue_in (enqueue_in),
    .dequeue_in (dequeue_in),
    .status_out (status_out),
    .data_out   (data_out)
  );

  // 1 MHz clock
  initial clock_1MHz = 1'b0;
  always #500 clock_1MHz = ~clock_1MHz;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock_1MHz);
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    @(negedge clock_1MHz);
    data_in  = b;
    write_in = 1'b1;
    cycles(hi);
    write_in = 1'b0;
    cycles(lo);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], 10, 10);
    end
  endtask

  task automatic dequeue(input int hi, input int lo);
    @(negedge clock_1MHz);
    dequeue_in = 1'b1;
    cycles(hi);
    dequeue_in = 1'b0;
    cycles(lo);
  endtask

  // Pop one word and compare against the scoreboard head
  task automatic deq_check(input string tag, input int hi, input int lo);
    logic [7:0] exp;
    dequeue(hi, lo);
    if (sb.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s observed=%02h expected=<scoreboard empty>", tag, data_out);
    end else begin
      exp = sb.pop_front();
      last_out = exp;
      check(tag, data_out, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock_1MHz);
    rst = 1'b1;
    cycles(n);
    check("reset_data_out", data_out, 8'h00);
    check("reset_status", {7'd0, status_out}, 8'h00);
    rst = 1'b0;
    sb.delete();
    last_out = 8'h00;
    cycles(1);
    check("status_after_reset", {7'd0, status_out}, 8'h01);
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    last_out   = 8'h00;
    rst        = 1'b1;
    data_in    = 1'b0;
    write_in   = 1'b0;
    enqueue_in = 1'bx;
    dequeue_in = 1'b0;

    // Reset for 3 cycles; FIFO must come up empty
    do_reset(3);
    dequeue(10, 10);
    check("empty_after_reset", data_out, 8'h00);

    // Single byte 1,0,0,0,0,0,0,0
    send_byte(8'h80);
    sb.push_back(8'h80);
    check("single_status", {7'd0, status_out}, 8'h01);
    deq_check("single_byte", 10, 10);
    check("single_status_after", {7'd0, status_out}, 8'h01);

    // Fill with 0x80..0x87
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h80 + 8'(i));
      sb.push_back(8'h80 + 8'(i));
    end
    check("fill_status", {7'd0, status_out}, 8'h01);

    // Ninth byte stalls the receiver; further strobes are ignored
    send_byte(8'h88);
    sb.push_back(8'h88);
    check("stall_status", {7'd0, status_out}, 8'h00);
    send_bit(1'b1, 10, 10);
    send_bit(1'b0, 10, 10);
    send_bit(1'b1, 10, 10);
    check("stall_status_hold", {7'd0, status_out}, 8'h00);

    // Drain 4 with slow strobes; stall releases after the first pop
    deq_check("drain_0", 200, 600);
    check("release_status", {7'd0, status_out}, 8'h01);
    deq_check("drain_1", 200, 600);
    deq_check("drain_2", 200, 600);
    deq_check("drain_3", 200, 600);

    // Drain the rest: 0x84..0x88
    for (int i = 0; i < 5; i++) begin
      deq_check($sformatf("drain_%0d", i + 4), 10, 10);
    end

    // Extra pop on an empty FIFO leaves data_out alone
    dequeue(10, 10);
    check("empty_pop_hold", data_out, last_out);

    // New bytes wrap the pointers
    send_byte(8'hA5);
    sb.push_back(8'hA5);
    send_byte(8'h3C);
    sb.push_back(8'h3C);
    send_byte(8'h01);
    sb.push_back(8'h01);
    deq_check("wrap_0", 10, 10);
    deq_check("wrap_1", 10, 10);
    deq_check("wrap_2", 10, 10);

    // Long write strobe captures exactly one bit
    send_bit(1'b1, 50, 10);
    send_bit(1'b0, 10, 10);
    send_bit(1'b1, 10, 10);
    send_bit(1'b0, 10, 10);
    send_bit(1'b1, 10, 10);
    send_bit(1'b0, 10, 10);
    send_bit(1'b1, 10, 10);
    send_bit(1'b0, 10, 10);
    sb.push_back(8'hAA);
    deq_check("long_strobe", 10, 10);

    // Reset mid-byte discards partial bits and queued words
    send_byte(8'h11);
    send_bit(1'b1, 10, 10);
    send_bit(1'b1, 10, 10);
    send_bit(1'b1, 10, 10);
    do_reset(3);
    send_byte(8'h5A);
    sb.push_back(8'h5A);
    deq_check("fresh_after_reset", 10, 10);
    dequeue(10, 10);
    check("empty_after_mid_reset", data_out, last_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
